// File: rtl/pipeline_stall_flush_ctrl.sv
// Central stall/flush scheduler for a 6-stage pipe (if, id, ex, mem1, mem2, wb).
// Merges per-stage stall requests into hold bits and per-boundary stall buses,
// and sequences exception/ERET redirects: a one-cycle flush, then a PC
// redirect that is deferred while fetch still has a bus transaction in flight.
module pipeline_stall_flush_ctrl #(
  parameter int NSTAGE = 6,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NSTAGE-1:0]       stall_req,
  input  logic                    exc_valid,
  input  logic [ADDR_W-1:0]       exc_pc,
  input  logic                    eret_valid,
  input  logic [ADDR_W-1:0]       epc,
  output logic [NSTAGE-1:0]       stall,
  output logic [2*(NSTAGE-1)-1:0] stall_bus,
  output logic                    flush,
  output logic                    redirect_valid,
  output logic [ADDR_W-1:0]       redirect_pc,
  output logic [1:0]              ctrl_state,
  output logic [CNT_W-1:0]        stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    WAIT_IF = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]    stall_cycles_q;
  logic [NSTAGE-1:0]   merged;

  // Backward OR-scan: a stall at stage j holds every earlier stage.
  always_comb begin
    logic acc;
    acc    = 1'b0;
    merged = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc       = acc | stall_req[i];
      merged[i] = acc;
    end
  end

  // Per-state output decode; outputs are forced quiet while reset is asserted.
  always_comb begin
    stall          = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RUN: stall = merged;
        FLUSH: begin
          flush          = 1'b1;
          redirect_valid = !stall_req[0];
        end
        WAIT_IF: begin
          stall[0]       = stall_req[0];
          redirect_valid = !stall_req[0];
        end
        default: stall = '0;
      endcase
    end
  end

  // Boundary k->k+1 bus is {stall[k], stall[k+1]}.
  always_comb begin
    stall_bus = '0;
    for (int unsigned k = 0; k < NSTAGE - 1; k++) begin
      stall_bus[2*k +: 2] = {stall[k], stall[k+1]};
    end
  end

  // Next-state and redirect target capture; redirect events only accepted in RUN.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    unique case (state_q)
      RUN: begin
        if (exc_valid || eret_valid) begin
          state_d  = FLUSH;
          target_d = exc_valid ? exc_pc : epc;
        end
      end
      FLUSH:   state_d = stall_req[0] ? WAIT_IF : RUN;
      WAIT_IF: state_d = stall_req[0] ? WAIT_IF : RUN;
      default: state_d = RUN;
    endcase
  end

  // State, target and saturating stall-cycle counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      target_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      if ((|stall) && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 1'b1;
      end
    end
  end

  assign redirect_pc  = target_q;
  assign ctrl_state   = state_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_stall_flush_ctrl.sv
// Self-checking bench for pipeline_stall_flush_ctrl: directed scenarios plus
// randomized traffic, compared each cycle against a behavioural model.
module tb_pipeline_stall_flush_ctrl;

  localparam int NS = 6;
  localparam int AW = 32;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [NS-1:0]   stall_req;
  logic            exc_valid;
  logic [AW-1:0]   exc_pc;
  logic            eret_valid;
  logic [AW-1:0]   epc;
  logic [NS-1:0]   stall;
  logic [2*(NS-1)-1:0] stall_bus;
  logic            flush;
  logic            redirect_valid;
  logic [AW-1:0]   redirect_pc;
  logic [1:0]      ctrl_state;
  logic [CW-1:0]   stall_cycles;

  pipeline_stall_flush_ctrl #(.NSTAGE(NS), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall_req(stall_req),
    .exc_valid(exc_valid), .exc_pc(exc_pc),
    .eret_valid(eret_valid), .epc(epc),
    .stall(stall), .stall_bus(stall_bus), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ctrl_state(ctrl_state), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: "a flush is due this cycle", "fetch redirect is pending".
  bit              m_valid = 1'b0;
  bit              m_flush_now;
  bit              m_redirect_pending;
  logic [AW-1:0]   m_target;
  logic [CW-1:0]   m_cnt;
  logic [NS-1:0]   e_stall;
  logic [2*(NS-1)-1:0] e_bus;
  logic            e_flush, e_rv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setin(input logic r, input logic [NS-1:0] req, input logic ex,
                       input logic [AW-1:0] xpc, input logic er, input logic [AW-1:0] ep);
    reset = r; stall_req = req; exc_valid = ex; exc_pc = xpc; eret_valid = er; epc = ep;
  endtask

  // Sample at the falling edge; inputs stay stable until after the next rising edge.
  task automatic at_neg();
    @(negedge clk);
    e_stall = '0; e_flush = 1'b0; e_rv = 1'b0;
    if (!reset) begin
      if (m_flush_now) begin
        e_flush = 1'b1;
        e_rv    = !stall_req[0];
      end else if (m_redirect_pending) begin
        e_stall[0] = stall_req[0];
        e_rv       = !stall_req[0];
      end else begin
        for (int i = 0; i < NS; i++) e_stall[i] = ((stall_req >> i) != 0);
      end
    end
    for (int k = 0; k < NS - 1; k++) e_bus[2*k +: 2] = {e_stall[k], e_stall[k+1]};
    if (m_valid) begin
      chk("stall", stall, e_stall);
      chk("stall_bus", stall_bus, e_bus);
      chk("flush", flush, e_flush);
      chk("redirect_valid", redirect_valid, e_rv);
      chk("redirect_pc", redirect_pc, m_target);
      chk("ctrl_state", ctrl_state, m_flush_now ? 2'd1 : (m_redirect_pending ? 2'd2 : 2'd0));
      chk("stall_cycles", stall_cycles, m_cnt);
    end
  endtask

  task automatic at_pos();
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b1; m_flush_now = 1'b0; m_redirect_pending = 1'b0;
      m_target = '0; m_cnt = '0;
    end else if (m_valid) begin
      if (e_stall != 0 && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
      if (m_flush_now) begin
        m_flush_now        = 1'b0;
        m_redirect_pending = stall_req[0];
      end else if (m_redirect_pending) begin
        m_redirect_pending = stall_req[0];
      end else if (exc_valid || eret_valid) begin
        m_flush_now = 1'b1;
        m_target    = exc_valid ? exc_pc : epc;
      end
    end
    #1;
  endtask

  task automatic cyc();
    at_neg();
    at_pos();
  endtask

  initial begin
    setin(1'b1, '0, 1'b0, '0, 1'b0, '0);
    cyc(); cyc();
    setin(1'b0, '0, 1'b0, '0, 1'b0, '0);
    at_neg();
    chk("rst_state", ctrl_state, 2'd0);
    chk("rst_cnt", stall_cycles, 32'd0);
    chk("rst_pc", redirect_pc, 32'd0);
    at_pos();

    // ex stall
    setin(1'b0, 6'b000100, 1'b0, '0, 1'b0, '0);
    at_neg();
    chk("t1_stall", stall, 6'b000111);
    chk("t1_bus54", stall_bus[5:4], 2'b10);
    chk("t1_bus30", stall_bus[3:0], 4'hF);
    at_pos();

    // mem2 + if stall
    setin(1'b0, 6'b010001, 1'b0, '0, 1'b0, '0);
    at_neg();
    chk("t2_stall", stall, 6'b011111);
    chk("t2_bus98", stall_bus[9:8], 2'b10);
    chk("t2_bus70", stall_bus[7:0], 8'hFF);
    at_pos();

    // exception, fetch idle
    setin(1'b0, '0, 1'b1, 32'hBFC00380, 1'b0, '0);
    cyc();
    setin(1'b0, '0, 1'b0, '0, 1'b0, '0);
    at_neg();
    chk("t3_flush", flush, 1'b1);
    chk("t3_rv", redirect_valid, 1'b1);
    chk("t3_pc", redirect_pc, 32'hBFC00380);
    at_pos();
    at_neg();
    chk("t3_flush_off", flush, 1'b0);
    chk("t3_rv_off", redirect_valid, 1'b0);
    at_pos();

    // ERET with fetch busy for 3 more cycles
    setin(1'b0, 6'b000001, 1'b0, '0, 1'b1, 32'h80001234);
    cyc();
    setin(1'b0, 6'b000001, 1'b0, '0, 1'b0, '0);
    at_neg();
    chk("t4_flush", flush, 1'b1);
    chk("t4_rv_flush", redirect_valid, 1'b0);
    at_pos();
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("t4_wait_state", ctrl_state, 2'd2);
      chk("t4_wait_stall", stall, 6'b000001);
      chk("t4_wait_rv", redirect_valid, 1'b0);
      at_pos();
    end
    setin(1'b0, '0, 1'b0, '0, 1'b0, '0);
    at_neg();
    chk("t4_rv", redirect_valid, 1'b1);
    chk("t4_pc", redirect_pc, 32'h80001234);
    chk("t4_stall0", stall, 6'b000000);
    at_pos();

    // exc and eret together, exc re-raised while busy
    setin(1'b0, 6'b000001, 1'b1, 32'h00000A00, 1'b1, 32'h00000B00);
    cyc();
    setin(1'b0, 6'b000001, 1'b1, 32'h00000C00, 1'b0, '0);
    at_neg(); chk("t5_flush", flush, 1'b1); at_pos();
    at_neg(); chk("t5_no_reflush", flush, 1'b0); at_pos();
    setin(1'b0, '0, 1'b1, 32'h00000D00, 1'b0, '0);
    at_neg();
    chk("t5_rv", redirect_valid, 1'b1);
    chk("t5_pc", redirect_pc, 32'h00000A00);
    at_pos();
    setin(1'b0, '0, 1'b0, '0, 1'b0, '0);
    at_neg(); chk("t5_run", ctrl_state, 2'd0); at_pos();

    // counter and reset during WAIT_IF
    setin(1'b1, '0, 1'b0, '0, 1'b0, '0);
    cyc();
    setin(1'b0, 6'b000010, 1'b0, '0, 1'b0, '0);
    repeat (5) cyc();
    setin(1'b0, '0, 1'b0, '0, 1'b0, '0);
    at_neg(); chk("t6_cnt5", stall_cycles, 32'd5); at_pos();
    setin(1'b0, 6'b000001, 1'b0, '0, 1'b1, 32'h12345678);
    cyc();
    setin(1'b0, 6'b000001, 1'b0, '0, 1'b0, '0);
    cyc(); cyc();
    setin(1'b1, '0, 1'b0, '0, 1'b0, '0);
    at_neg(); chk("t6_rst_rv", redirect_valid, 1'b0); at_pos();
    setin(1'b0, '0, 1'b0, '0, 1'b0, '0);
    at_neg();
    chk("t6_state", ctrl_state, 2'd0);
    chk("t6_cnt0", stall_cycles, 32'd0);
    chk("t6_rv", redirect_valid, 1'b0);
    at_pos();

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      logic [NS-1:0] req;
      for (int b = 0; b < NS; b++) req[b] = ($urandom_range(3) == 0);
      req[0] = $urandom_range(1);
      setin($urandom_range(99) == 0, req,
            $urandom_range(11) == 0, $urandom, $urandom_range(11) == 0, $urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
